// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel two-flop synchroniser + stability-counter debouncer with rise/fall strobes
// Optional long-press detector enabled by defining MULTI_DEBOUNCER_LONG_PRESS_EN.
module multi_debouncer #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 786432,
    parameter int   CNT_W         = 20,
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   HOLD_CYCLES   = 50000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (CHANNELS < 1 || CHANNELS > 32 || STABLE_CYCLES < 2 || HOLD_CYCLES < 1 ||
        (2 ** CNT_W) <= STABLE_CYCLES) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] clean_q, clean_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    // The counter only runs while the synchronised input disagrees with the clean level.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= {CHANNELS{INIT_LEVEL}};
            sync2_q <= {CHANNELS{INIT_LEVEL}};
            clean_q <= {CHANNELS{INIT_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0]    hcnt_q [CHANNELS];
    logic [CNT_W-1:0]    hcnt_d [CHANNELS];
    logic [CHANNELS-1:0] hold_q, hold_d;

    // Saturation at HOLD_MAX is what keeps the pulse from repeating during one press.
    always_comb begin
        hold_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hcnt_d[i] = '0;
            if (clean_q[i]) begin
                hcnt_d[i] = (hcnt_q[i] == HOLD_MAX) ? hcnt_q[i] : hcnt_q[i] + CNT_ONE;
                hold_d[i] = (hcnt_q[i] == HOLD_PRE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt_q[i] <= '0;
            end
        end else begin
            hold_q <= hold_d;
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign hold = hold_q;
`else
    assign hold = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed self-checking bench for multi_debouncer (4 channels, 4-cycle filter)
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] clean, rise, fall, hold;

    int errors = 0;
    int checks = 0;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    multi_debouncer #(
        .CHANNELS     (4),
        .STABLE_CYCLES(4),
        .CNT_W        (4),
        .INIT_LEVEL   (1'b0),
        .HOLD_CYCLES  (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw),
        .clean(clean),
        .rise (rise),
        .fall (fall),
        .hold (hold)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic [3:0] exp_clean, input bit chk_hold);
        chk({tag, "_clean"}, clean, exp_clean);
        chk({tag, "_rise"}, rise, 4'h0);
        chk({tag, "_fall"}, fall, 4'h0);
        if (chk_hold || !HOLD_ON) chk({tag, "_hold"}, hold, 4'h0);
    endtask

    // Apply a raw step and expect the flip on exactly the 6th edge, strobes for one cycle.
    task automatic run_step(input string tag, input logic [3:0] new_raw,
                            input logic [3:0] old_clean, input logic [3:0] new_clean,
                            input logic [3:0] exp_rise, input logic [3:0] exp_fall,
                            input bit chk_hold);
        raw = new_raw;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_quiet({tag, "_wait"}, old_clean, chk_hold);
        end
        tick();
        chk({tag, "_flip_clean"}, clean, new_clean);
        chk({tag, "_flip_rise"}, rise, exp_rise);
        chk({tag, "_flip_fall"}, fall, exp_fall);
        tick();
        chk_quiet({tag, "_after"}, new_clean, chk_hold);
    endtask

    initial begin
        rst_n = 1'b0;
        raw   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("reset", 4'h0, 1'b1);
        end

        rst_n = 1'b1;
        run_step("release", 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b1);
        run_step("all_low", 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1);

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
        run_step("lp_rise", 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("lp_hold", hold, (i == 9) ? 4'h1 : 4'h0);
        end
        run_step("lp_fall", 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
        run_step("sp_rise", 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1);
        tick();
        chk("sp_hold", hold, 4'h0);
        run_step("sp_fall", 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sp_tail_hold", hold, 4'h0);
        end
`endif

        run_step("ch0_rise", 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0);
        run_step("ch0_fall", 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);

        // Bounce: 2-cycle pulses never survive long enough to reach the threshold.
        for (int p = 0; p < 4; p++) begin
            raw = (p % 2 == 0) ? 4'h2 : 4'h0;
            for (int k = 0; k < 2; k++) begin
                tick();
                chk_quiet("bounce", 4'h0, 1'b0);
            end
        end
        run_step("bounce_settle", 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 1'b0);
        run_step("ch1_fall", 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 1'b0);

        // Near miss: three mismatch cycles take cnt to STABLE_CYCLES-1, then it must clear.
        raw = 4'h4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("near_hi", 4'h0, 1'b0);
        end
        raw = 4'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_quiet("near_lo", 4'h0, 1'b0);
        end
        run_step("near_recount", 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 1'b0);
        run_step("ch2_fall", 4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0);

        run_step("ch3_rise", 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 1'b0);
        run_step("simul", 4'h1, 4'h8, 4'h1, 4'h1, 4'h8, 1'b0);

        raw = 4'h3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("midcount", 4'h1, 1'b0);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_quiet("mid_reset", 4'h0, 1'b0);
        end
        rst_n = 1'b1;
        run_step("rst_recount", 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
